exec_stage: RTL and testbench
=============================

Name: exec_stage

Overview:
- EX stage of the 5-stage pipeline, directly upstream of the memory stage. Executes ALU ops and an iterative 32-cycle multiply/divide unit that owns the HI/LO registers.
- Holds the EX/MEM pipeline register driving aluOutM, writeDataM, writeRegM and memWriteM into the memory stage.
- Raises stallE to the hazard unit while a MULT/DIV result is pending and needed.

Parameters:
WIDTH, 32, datapath width
MD_CYCLES, 32, iterations per multiply/divide (equals WIDTH)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous active-high reset
srcAE  input  32  operand A (already forwarded)
srcBE  input  32  operand B register value (already forwarded)
immE  input  32  sign/zero-extended immediate
shamtE  input  5  shift amount
aluSrcE  input  1  1: B operand = immE; 0: srcBE
aluControlE  input  4  operation select (see Behaviour)
unsignedE  input  1  MULT/DIV/SLT treat operands as unsigned
writeRegE  input  5  destination register
regWriteE  input  1  instruction writes register file
memWriteE  input  1  store
memToRegE  input  1  load
flushE  input  1  kill instruction in EX
aluOutM  output  32  registered result/address to memory stage
writeDataM  output  32  registered store data (srcBE)
writeRegM  output  5  registered destination
regWriteM  output  1  registered
memWriteM  output  1  registered
memToRegM  output  1  registered
stallE  output  1  combinational stall request
mdBusy  output  1  multiply/divide unit running

Behaviour:
- Reset (async): all M outputs 0, HI=LO=0, mdBusy=0, counter 0. Reset mid-MULT/DIV aborts it; HI/LO stay 0.
- aluControlE: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 NOR, 0110 SUB, 0111 SLT (SLTU if unsignedE), 1001 SLL, 1010 SRL, 1011 SRA (by shamtE, on B), 1100 MFHI, 1101 MFLO, 1110 MULT, 1111 DIV; 0101/1000 produce 0.
- ADD/SUB wrap modulo 2^32; no overflow trap. SLT result is 0 or 1.
- EX/MEM register: 1-cycle latency; updates every clk edge.
- Bubble (regWriteM=0, memWriteM=0, memToRegM=0, aluOutM/writeDataM/writeRegM=0) when flushE or stallE.
- stallE = mdBusy AND aluControlE in {MFHI, MFLO, MULT, DIV} AND NOT flushE. Other instructions proceed while unit runs.
- MD start: edge where aluControlE is MULT/DIV, mdBusy=0, no flushE. Operands latched; mdBusy=1 for exactly MD_CYCLES cycles; HI/LO updated on the edge mdBusy falls; MFHI/MFLO in the next cycle sees new values. The MULT/DIV itself retires as bubble-free no-write (regWriteM as supplied, normally 0).
- MULT: shift-add on magnitudes; signed mode negates 64-bit product if signs differ. HI = upper 32 bits, LO = lower 32 bits.
- DIV: restoring on magnitudes. LO=quotient; HI=remainder. Signed: quotient negated if signs differ; remainder takes dividend's sign.
- DIV by 0: LO=0xFFFFFFFF (unsigned) / raw restoring result with sign fix (signed), HI=dividend. No exception.
- Signed 0x80000000 / -1: LO=0x80000000, HI=0.
- flushE on the start cycle: no start. A flush during an in-progress op does not abort it.
- MULT/DIV arriving while busy: stalls and starts on the edge mdBusy falls (stallE drops the same cycle).

Test Plan:
- ADD srcA=0x7FFFFFFF, B=1 -> next cycle aluOutM=0x80000000, regWriteM passes through; SUB 5-7 -> 0xFFFFFFFE.
- SLT -1<1 signed -> 1; unsignedE=1 -> 0; SRA 0x80000000 by 4 -> 0xF8000000.
- Signed MULT -3 x 7 -> mdBusy 32 cycles; then MFLO gives 0xFFFFFFEB, MFHI 0xFFFFFFFF. MFLO issued the cycle after MULT holds stallE=1 for 32 cycles with bubbles into M.
- Signed DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 10/0 -> LO=0xFFFFFFFF, HI=10.
- Store with memWriteE=1, flushE=1 -> memWriteM=0, aluOutM=0; independent ADD during busy -> no stall.
- reset asserted at iteration 10 of MULT -> mdBusy=0, HI=LO=0, all M outputs 0 immediately.

Source files
------------

// File: rtl/exec_stage.sv
// Execute stage: single-cycle ALU plus an iterative multiply/divide unit that owns HI/LO,
// feeding the EX/MEM pipeline register that drives the memory stage.
`timescale 1ns/1ps
module exec_stage #(
  parameter int WIDTH     = 32,
  parameter int MD_CYCLES = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] srcAE,
  input  logic [WIDTH-1:0] srcBE,
  input  logic [WIDTH-1:0] immE,
  input  logic [4:0]       shamtE,
  input  logic             aluSrcE,
  input  logic [3:0]       aluControlE,
  input  logic             unsignedE,
  input  logic [4:0]       writeRegE,
  input  logic             regWriteE,
  input  logic             memWriteE,
  input  logic             memToRegE,
  input  logic             flushE,
  output logic [WIDTH-1:0] aluOutM,
  output logic [WIDTH-1:0] writeDataM,
  output logic [4:0]       writeRegM,
  output logic             regWriteM,
  output logic             memWriteM,
  output logic             memToRegM,
  output logic             stallE,
  output logic             mdBusy
);

  localparam int CW = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_NOR  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1001;
  localparam logic [3:0] OP_SRL  = 4'b1010;
  localparam logic [3:0] OP_SRA  = 4'b1011;
  localparam logic [3:0] OP_MFHI = 4'b1100;
  localparam logic [3:0] OP_MFLO = 4'b1101;
  localparam logic [3:0] OP_MULT = 4'b1110;
  localparam logic [3:0] OP_DIV  = 4'b1111;

  logic [WIDTH-1:0]   b_op;
  logic [WIDTH-1:0]   alu_result;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic [WIDTH-1:0]   md_b;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] acc_neg;
  logic [CW-1:0]      count;
  logic               md_is_div;
  logic               neg_low;
  logic               neg_high;
  logic               is_muldiv;
  logic               uses_md;
  logic               finishing;
  logic               start;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_trial;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  assign b_op = aluSrcE ? immE : srcBE;

  always_comb begin
    alu_result = '0;
    case (aluControlE)
      OP_AND:  alu_result = srcAE & b_op;
      OP_OR:   alu_result = srcAE | b_op;
      OP_ADD:  alu_result = srcAE + b_op;
      OP_XOR:  alu_result = srcAE ^ b_op;
      OP_NOR:  alu_result = ~(srcAE | b_op);
      OP_SUB:  alu_result = srcAE - b_op;
      OP_SLT:  alu_result = unsignedE ? WIDTH'(srcAE < b_op)
                                      : WIDTH'($signed(srcAE) < $signed(b_op));
      OP_SLL:  alu_result = b_op << shamtE;
      OP_SRL:  alu_result = b_op >> shamtE;
      OP_SRA:  alu_result = WIDTH'($signed(b_op) >>> shamtE);
      OP_MFHI: alu_result = hi;
      OP_MFLO: alu_result = lo;
      default: alu_result = '0;
    endcase
  end

  // A MULT/DIV waiting behind a running op is released in the unit's final cycle,
  // so it starts on the very edge the previous result lands in HI/LO.
  assign is_muldiv = (aluControlE == OP_MULT) || (aluControlE == OP_DIV);
  assign uses_md   = is_muldiv || (aluControlE == OP_MFHI) || (aluControlE == OP_MFLO);
  assign finishing = mdBusy && (count == CW'(MD_CYCLES - 1));
  assign start     = is_muldiv && !flushE && (!mdBusy || finishing);
  assign stallE    = mdBusy && uses_md && !flushE && !(finishing && is_muldiv);

  assign a_neg = !unsignedE && srcAE[WIDTH-1];
  assign b_neg = !unsignedE && b_op[WIDTH-1];
  assign a_mag = a_neg ? -srcAE : srcAE;
  assign b_mag = b_neg ? -b_op : b_op;

  // One iteration: shift-add multiply on {HI-accum, multiplier}, or restoring
  // divide on {remainder, dividend/quotient}; md_b holds multiplicand or divisor.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, md_b} : '0);
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_trial = div_shift - {1'b0, md_b};
    if (!md_is_div)
      acc_step = {mul_sum, acc[WIDTH-1:1]};
    else if (div_trial[WIDTH])
      acc_step = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    else
      acc_step = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end

  assign acc_neg = -acc_step;

  always_comb begin
    if (!md_is_div) begin
      res_hi = neg_low ? acc_neg[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];
      res_lo = neg_low ? acc_neg[WIDTH-1:0]       : acc_step[WIDTH-1:0];
    end else begin
      res_hi = neg_high ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];
      res_lo = neg_low  ? -acc_step[WIDTH-1:0]       : acc_step[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mdBusy    <= 1'b0;
      count     <= '0;
      acc       <= '0;
      md_b      <= '0;
      md_is_div <= 1'b0;
      neg_low   <= 1'b0;
      neg_high  <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      if (mdBusy) begin
        acc   <= acc_step;
        count <= count + CW'(1);
        if (finishing) begin
          hi     <= res_hi;
          lo     <= res_lo;
          mdBusy <= 1'b0;
        end
      end
      if (start) begin
        mdBusy    <= 1'b1;
        count     <= '0;
        md_is_div <= (aluControlE == OP_DIV);
        neg_low   <= a_neg ^ b_neg;
        neg_high  <= a_neg;
        if (aluControlE == OP_DIV) begin
          acc  <= {{WIDTH{1'b0}}, a_mag};
          md_b <= b_mag;
        end else begin
          acc  <= {{WIDTH{1'b0}}, b_mag};
          md_b <= a_mag;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aluOutM    <= '0;
      writeDataM <= '0;
      writeRegM  <= '0;
      regWriteM  <= 1'b0;
      memWriteM  <= 1'b0;
      memToRegM  <= 1'b0;
    end else if (flushE || stallE) begin
      aluOutM    <= '0;
      writeDataM <= '0;
      writeRegM  <= '0;
      regWriteM  <= 1'b0;
      memWriteM  <= 1'b0;
      memToRegM  <= 1'b0;
    end else begin
      aluOutM    <= alu_result;
      writeDataM <= srcBE;
      writeRegM  <= writeRegE;
      regWriteM  <= regWriteE;
      memWriteM  <= memWriteE;
      memToRegM  <= memToRegE;
    end
  end

endmodule

// File: tb/tb_exec_stage.sv
// Self-checking bench for exec_stage: table of single-cycle ALU vectors followed by
// hand-written multiply/divide, stall, flush and mid-operation reset sequences.
`timescale 1ns/1ps
module tb_exec_stage;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_NOR  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1001;
  localparam logic [3:0] OP_SRL  = 4'b1010;
  localparam logic [3:0] OP_SRA  = 4'b1011;
  localparam logic [3:0] OP_MFHI = 4'b1100;
  localparam logic [3:0] OP_MFLO = 4'b1101;
  localparam logic [3:0] OP_MULT = 4'b1110;
  localparam logic [3:0] OP_DIV  = 4'b1111;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] srcAE, srcBE, immE;
  logic [4:0]  shamtE, writeRegE;
  logic        aluSrcE, unsignedE, regWriteE, memWriteE, memToRegE, flushE;
  logic [3:0]  aluControlE;
  logic [31:0] aluOutM, writeDataM;
  logic [4:0]  writeRegM;
  logic        regWriteM, memWriteM, memToRegM, stallE, mdBusy;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    string       name;
    logic [3:0]  ctrl;
    logic [31:0] a, b, imm;
    logic        aluSrc;
    logic [4:0]  shamt;
    logic        uns, regWrite, memWrite, memToReg, flush;
    logic [4:0]  wreg;
    logic [31:0] expOut;
  } vecT;

  vecT vecs[$];

  exec_stage dut (
    .clk(clk), .reset(reset), .srcAE(srcAE), .srcBE(srcBE), .immE(immE),
    .shamtE(shamtE), .aluSrcE(aluSrcE), .aluControlE(aluControlE),
    .unsignedE(unsignedE), .writeRegE(writeRegE), .regWriteE(regWriteE),
    .memWriteE(memWriteE), .memToRegE(memToRegE), .flushE(flushE),
    .aluOutM(aluOutM), .writeDataM(writeDataM), .writeRegM(writeRegM),
    .regWriteM(regWriteM), .memWriteM(memWriteM), .memToRegM(memToRegM),
    .stallE(stallE), .mdBusy(mdBusy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                               input logic uns, input logic regWrite);
    aluControlE = ctrl;
    srcAE       = a;
    srcBE       = b;
    immE        = 32'h0;
    aluSrcE     = 1'b0;
    shamtE      = 5'd0;
    unsignedE   = uns;
    regWriteE   = regWrite;
    memWriteE   = 1'b0;
    memToRegE   = 1'b0;
    flushE      = 1'b0;
    writeRegE   = 5'd3;
  endtask

  task automatic addVec(input string name, input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input logic aluSrc, input logic [4:0] shamt, input logic uns,
                        input logic regWrite, input logic memWrite, input logic memToReg, input logic flush,
                        input logic [4:0] wreg, input logic [31:0] expOut);
    vecT v;
    v.name = name; v.ctrl = ctrl; v.a = a; v.b = b; v.imm = imm; v.aluSrc = aluSrc;
    v.shamt = shamt; v.uns = uns; v.regWrite = regWrite; v.memWrite = memWrite;
    v.memToReg = memToReg; v.flush = flush; v.wreg = wreg; v.expOut = expOut;
    vecs.push_back(v);
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    while (mdBusy && n < 60) begin
      tick();
      n++;
    end
    checkOutput({name, "_done"}, 32'(mdBusy), 32'h0);
  endtask

  task automatic readHiLo(input string name, input logic [31:0] expLo, input logic [31:0] expHi);
    applyStimulus(OP_MFLO, 32'h0, 32'h0, 1'b0, 1'b1);
    tick();
    checkOutput({name, "_lo"}, aluOutM, expLo);
    applyStimulus(OP_MFHI, 32'h0, 32'h0, 1'b0, 1'b1);
    tick();
    checkOutput({name, "_hi"}, aluOutM, expHi);
  endtask

  initial begin
    int stallCycles;
    logic [7:0] expCtl;

    // Reset holds everything at zero even with a writing ADD presented.
    reset = 1'b1;
    applyStimulus(OP_ADD, 32'h1, 32'h2, 1'b0, 1'b1);
    tick();
    tick();
    checkOutput("reset_aluOut", aluOutM, 32'h0);
    checkOutput("reset_regWrite", 32'(regWriteM), 32'h0);
    checkOutput("reset_mdBusy", 32'(mdBusy), 32'h0);
    reset = 1'b0;

    addVec("add_wrap",   OP_ADD,  32'h7FFFFFFF, 32'h1,        32'h0, 0, 5'd0,  0, 1, 0, 0, 0, 5'd5,  32'h80000000);
    addVec("sub",        OP_SUB,  32'd5,        32'd7,        32'h0, 0, 5'd0,  0, 1, 0, 0, 0, 5'd6,  32'hFFFFFFFE);
    addVec("slt_s",      OP_SLT,  32'hFFFFFFFF, 32'h1,        32'h0, 0, 5'd0,  0, 1, 0, 0, 0, 5'd7,  32'h1);
    addVec("slt_u",      OP_SLT,  32'hFFFFFFFF, 32'h1,        32'h0, 0, 5'd0,  1, 1, 0, 0, 0, 5'd7,  32'h0);
    addVec("slt_s_neg",  OP_SLT,  32'd5,        32'hFFFFFFFD, 32'h0, 0, 5'd0,  0, 1, 0, 0, 0, 5'd8,  32'h0);
    addVec("slt_u_big",  OP_SLT,  32'd5,        32'hFFFFFFFD, 32'h0, 0, 5'd0,  1, 1, 0, 0, 0, 5'd8,  32'h1);
    addVec("sra",        OP_SRA,  32'h12345678, 32'h80000000, 32'h0, 0, 5'd4,  0, 1, 0, 0, 0, 5'd9,  32'hF8000000);
    addVec("sll",        OP_SLL,  32'h0,        32'h1,        32'h0, 0, 5'd31, 0, 1, 0, 0, 0, 5'd10, 32'h80000000);
    addVec("srl",        OP_SRL,  32'h0,        32'h80000000, 32'h0, 0, 5'd4,  0, 1, 0, 0, 0, 5'd11, 32'h08000000);
    addVec("and",        OP_AND,  32'hF0F000FF, 32'h0FF00F0F, 32'h0, 0, 5'd0,  0, 1, 0, 0, 0, 5'd12, 32'h00F0000F);
    addVec("or",         OP_OR,   32'hF0F000FF, 32'h0FF00F0F, 32'h0, 0, 5'd0,  0, 1, 0, 0, 0, 5'd13, 32'hFFF00FFF);
    addVec("xor",        OP_XOR,  32'hF0F000FF, 32'h0FF00F0F, 32'h0, 0, 5'd0,  0, 1, 0, 0, 0, 5'd14, 32'hFF000FF0);
    addVec("nor",        OP_NOR,  32'h0000FFFF, 32'h00FF0000, 32'h0, 0, 5'd0,  0, 1, 0, 0, 0, 5'd15, 32'hFF000000);
    addVec("add_imm",    OP_ADD,  32'd100,      32'd5,        32'hFFFFFFFF, 1, 5'd0, 0, 1, 0, 0, 0, 5'd16, 32'h00000063);
    addVec("op_0101",    4'b0101, 32'h1,        32'h1,        32'h0, 0, 5'd0,  0, 1, 0, 0, 0, 5'd17, 32'h0);
    addVec("op_1000",    4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 0, 5'd0,  0, 1, 0, 0, 0, 5'd18, 32'h0);
    addVec("store_fl",   OP_ADD,  32'h1000,     32'hDEADBEEF, 32'h8, 1, 5'd0,  0, 0, 1, 0, 1, 5'd0,  32'h0);
    addVec("store",      OP_ADD,  32'h1000,     32'hDEADBEEF, 32'h8, 1, 5'd0,  0, 0, 1, 0, 0, 5'd0,  32'h00001008);
    addVec("load",       OP_ADD,  32'h1000,     32'h0,        32'h4, 1, 5'd0,  0, 1, 0, 1, 0, 5'd19, 32'h00001004);

    foreach (vecs[i]) begin
      aluControlE = vecs[i].ctrl;
      srcAE       = vecs[i].a;
      srcBE       = vecs[i].b;
      immE        = vecs[i].imm;
      aluSrcE     = vecs[i].aluSrc;
      shamtE      = vecs[i].shamt;
      unsignedE   = vecs[i].uns;
      regWriteE   = vecs[i].regWrite;
      memWriteE   = vecs[i].memWrite;
      memToRegE   = vecs[i].memToReg;
      flushE      = vecs[i].flush;
      writeRegE   = vecs[i].wreg;
      tick();
      expCtl = vecs[i].flush ? 8'h0
             : {vecs[i].wreg, vecs[i].regWrite, vecs[i].memWrite, vecs[i].memToReg};
      checkOutput({vecs[i].name, "_out"}, aluOutM, vecs[i].expOut);
      checkOutput({vecs[i].name, "_data"}, writeDataM, vecs[i].flush ? 32'h0 : vecs[i].b);
      checkOutput({vecs[i].name, "_ctl"}, 32'({writeRegM, regWriteM, memWriteM, memToRegM}), 32'(expCtl));
    end

    // Signed MULT -3 x 7, then MFLO right behind it stalls for the whole run.
    applyStimulus(OP_MULT, 32'hFFFFFFFD, 32'd7, 1'b0, 1'b0);
    tick();
    checkOutput("mult_busy", 32'(mdBusy), 32'h1);
    applyStimulus(OP_MFLO, 32'h0, 32'h0, 1'b0, 1'b1);
    #1;
    checkOutput("mflo_stall", 32'(stallE), 32'h1);
    stallCycles = 0;
    while (stallE && stallCycles < 100) begin
      tick();
      stallCycles++;
      if (stallCycles == 5) begin
        checkOutput("stall_bubble_out", aluOutM, 32'h0);
        checkOutput("stall_bubble_rw", 32'(regWriteM), 32'h0);
      end
    end
    checkOutput("mflo_stall_cycles", 32'(stallCycles), 32'd32);
    checkOutput("mult_idle", 32'(mdBusy), 32'h0);
    tick();
    checkOutput("mult_lo", aluOutM, 32'hFFFFFFEB);
    applyStimulus(OP_MFHI, 32'h0, 32'h0, 1'b0, 1'b1);
    tick();
    checkOutput("mult_hi", aluOutM, 32'hFFFFFFFF);

    // Signed DIV -7/2 with an independent ADD flowing past the busy unit.
    applyStimulus(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
    tick();
    applyStimulus(OP_ADD, 32'd20, 32'd22, 1'b0, 1'b1);
    #1;
    checkOutput("add_nostall", 32'(stallE), 32'h0);
    tick();
    checkOutput("add_busy_out", aluOutM, 32'd42);
    checkOutput("add_busy_rw", 32'(regWriteM), 32'h1);
    applyStimulus(OP_AND, 32'h0, 32'h0, 1'b0, 1'b0);
    waitIdle("div_s");
    readHiLo("div_s", 32'hFFFFFFFD, 32'hFFFFFFFF);

    applyStimulus(OP_DIV, 32'd10, 32'd0, 1'b1, 1'b0);
    tick();
    applyStimulus(OP_AND, 32'h0, 32'h0, 1'b0, 1'b0);
    waitIdle("divu_zero");
    readHiLo("divu_zero", 32'hFFFFFFFF, 32'd10);

    applyStimulus(OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0);
    tick();
    applyStimulus(OP_AND, 32'h0, 32'h0, 1'b0, 1'b0);
    waitIdle("multu_max");
    readHiLo("multu_max", 32'h00000001, 32'hFFFFFFFE);

    applyStimulus(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
    tick();
    applyStimulus(OP_AND, 32'h0, 32'h0, 1'b0, 1'b0);
    waitIdle("div_ovf");
    readHiLo("div_ovf", 32'h80000000, 32'h0);

    // A flushed DIV never starts, so HI/LO keep the previous result.
    applyStimulus(OP_DIV, 32'd100, 32'd3, 1'b0, 1'b0);
    flushE = 1'b1;
    tick();
    checkOutput("flush_nostart", 32'(mdBusy), 32'h0);
    readHiLo("flush_keep", 32'h80000000, 32'h0);

    // Reset ten iterations into a MULT clears the unit, HI/LO and the M register at once.
    applyStimulus(OP_MULT, 32'd5, 32'd6, 1'b1, 1'b0);
    tick();
    applyStimulus(OP_ADD, 32'd1, 32'd2, 1'b0, 1'b1);
    for (int k = 0; k < 10; k++) tick();
    checkOutput("pre_reset_out", aluOutM, 32'd3);
    reset = 1'b1;
    #1;
    checkOutput("midreset_busy", 32'(mdBusy), 32'h0);
    checkOutput("midreset_out", aluOutM, 32'h0);
    checkOutput("midreset_ctl", 32'({writeRegM, regWriteM, memWriteM, memToRegM}), 32'h0);
    tick();
    reset = 1'b0;
    readHiLo("midreset", 32'h0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
